// File: rtl/dbus_interconnect.sv
// dbus_interconnect: single-outstanding data-bus fabric between the processor
// data port and NUM_SLAVES memory-mapped targets. Decodes the request address,
// strobes the selected slave until it returns valid and answers the processor
// with a one-cycle response pulse. Unmapped addresses and slaves that stay
// silent for TIMEOUT cycles get a bus error.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   ip_data_*           processor request (addr, wr, rd, mask, write data)
//   op_data_valid/err   one-cycle response pulse and its error qualifier
//   op_data_to_proc     read data (0 for writes, ERR_DATA on read errors)
//   op_s_addr/mask/wdata latched request, broadcast to every slave
//   op_s_wr/op_s_rd     per-slave strobes, held until the slave answers
//   ip_s_valid/rdata    per-slave completion and read data (slice i = slave i)
module dbus_interconnect #(
  parameter int unsigned                NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE = {32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK = {32'hFFFF_F000, 32'hFFFF_F000},
  parameter int unsigned                TIMEOUT    = 255,
  parameter logic [31:0]                ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              ip_data_addr,
  input  logic                     ip_data_wr,
  input  logic [3:0]               ip_data_mask,
  input  logic [31:0]              ip_data_from_proc,
  input  logic                     ip_data_rd,
  output logic                     op_data_valid,
  output logic [31:0]              op_data_to_proc,
  output logic                     op_data_err,
  output logic [31:0]              op_s_addr,
  output logic [3:0]               op_s_mask,
  output logic [31:0]              op_s_wdata,
  output logic [NUM_SLAVES-1:0]    op_s_wr,
  output logic [NUM_SLAVES-1:0]    op_s_rd,
  input  logic [NUM_SLAVES-1:0]    ip_s_valid,
  input  logic [NUM_SLAVES*32-1:0] ip_s_rdata
);

  localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic                   is_wr_q, is_wr_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [31:0]            addr_q, addr_d;
  logic [3:0]             mask_q, mask_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [NUM_SLAVES-1:0]  s_wr_q, s_wr_d;
  logic [NUM_SLAVES-1:0]  s_rd_q, s_rd_d;

  logic                   dec_hit;
  logic [SEL_W-1:0]       dec_sel;
  logic                   sel_valid;
  logic [31:0]            sel_rdata;

  // Address decode: walk from the top so the lowest matching index wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((ip_data_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        dec_hit = 1'b1;
        dec_sel = SEL_W'(i);
      end
    end
  end

  // Completion mux for the slave currently being served.
  always_comb begin
    sel_valid = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_valid = ip_s_valid[i];
        sel_rdata = ip_s_rdata[i*32 +: 32];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    is_wr_d = is_wr_q;
    valid_d = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    wdata_d = wdata_q;
    s_wr_d  = s_wr_q;
    s_rd_d  = s_rd_q;

    case (state_q)
      IDLE: begin
        if (ip_data_rd || ip_data_wr) begin
          addr_d  = ip_data_addr;
          mask_d  = ip_data_mask;
          wdata_d = ip_data_from_proc;
          is_wr_d = ip_data_wr;  // rd+wr together is a write
          if (dec_hit) begin
            state_d = BUSY;
            sel_d   = dec_sel;
            cnt_d   = '0;
            if (ip_data_wr) s_wr_d = NUM_SLAVES'(1) << dec_sel;
            else            s_rd_d = NUM_SLAVES'(1) << dec_sel;
          end else begin
            state_d = RESP;
            valid_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = ip_data_wr ? 32'h0 : ERR_DATA;
          end
        end
      end

      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Slave valid takes priority over a timeout in the same cycle.
        if (sel_valid) begin
          state_d = RESP;
          valid_d = 1'b1;
          err_d   = 1'b0;
          rdata_d = is_wr_q ? 32'h0 : sel_rdata;
          s_wr_d  = '0;
          s_rd_d  = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th strobe cycle with no answer.
          state_d = RESP;
          valid_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = is_wr_q ? 32'h0 : ERR_DATA;
          s_wr_d  = '0;
          s_rd_d  = '0;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        s_wr_d  = '0;
        s_rd_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      is_wr_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      s_wr_q  <= '0;
      s_rd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      is_wr_q <= is_wr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      s_wr_q  <= s_wr_d;
      s_rd_q  <= s_rd_d;
    end
  end

  assign op_data_valid   = valid_q;
  assign op_data_err     = err_q;
  assign op_data_to_proc = rdata_q;
  assign op_s_addr       = addr_q;
  assign op_s_mask       = mask_q;
  assign op_s_wdata      = wdata_q;
  assign op_s_wr         = s_wr_q;
  assign op_s_rd         = s_rd_q;

endmodule
